multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised multi-channel programmable timer device for the MIPS microsystem bus; the next generation of the single-channel system timer.
- NUM_CH independent down-counters, each with a per-channel prescaler, one-shot / auto-reload / silent-periodic modes, a maskable W1C interrupt-pending bit, and a per-channel IRQ line plus an OR-combined IRQ.
- Sits beside the segment/IO devices on the CPU device bus; irq_any feeds the CPU interrupt input.

Parameters:
- NUM_CH, 2, number of timer channels, legal 1..4.
- CNT_W, 32, counter/preset width, legal 8..32. Reads zero-extend to 32 bits; writes use wdata[CNT_W-1:0].

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  bus write strobe for the current cycle.
- addr  input  4  word index: addr[3:2] selects the channel, addr[1:0] selects the register.
- wdata  input  32  write data.
- rdata  output  32  combinational read data for addr.
- irq  output  NUM_CH  per-channel interrupt, equal to pending & IM.
- irq_any  output  1  OR of irq.

Behaviour:
- Register map per channel (addr[1:0]):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM, bits7:4 PS. Upper bits read as 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3 STATUS: bit0 pending; write 1 clears it, write 0 has no effect.
- Channel index >= NUM_CH: reads return 0, writes ignored.
- Reset: all CTRL, PRESET, COUNT, pending and prescaler registers are 0; every channel is IDLE; irq=0; irq_any=0. Reset mid-count aborts immediately with no pending bit set.
- Per-channel states and transitions:
  - IDLE: COUNT holds. A CTRL write with EN=1 moves to LOAD.
  - LOAD: one cycle. COUNT<=PRESET, prescaler<=0, then go to COUNT.
  - COUNT: if COUNT==0, terminal event this edge. Otherwise, on a prescale tick, COUNT<=COUNT-1.
- Prescale tick: fires when the prescaler equals 2^PS-1; the prescaler then wraps to 0. It increments every cycle in the COUNT state, so PS=0 gives a tick every cycle.
- Terminal event by MODE:
  - 0 (and reserved 3), one-shot: pending<=1, EN<=0, go to IDLE; COUNT stays 0.
  - 1, auto-reload: pending<=1, go to LOAD.
  - 2, silent periodic: pending unchanged, go to LOAD.
- Timing, PS=0, preset P:
  - CTRL write EN=1 at edge t gives LOAD after t.
  - COUNT=P after edge t+1.
  - COUNT=0 after edge t+1+P.
  - pending=1 after edge t+2+P.
  - Mode 1/2 period is P+2 cycles.
  - P=0 is legal: terminal event on the first COUNT cycle.
- CTRL write rules:
  - EN=0 while running: go to IDLE at the next edge, COUNT freezes.
  - EN=1 while already running: restart via LOAD.
  - MODE, IM and PS changes take effect at the next edge.
- A PRESET write takes effect only at the next LOAD. PRESET written in the same cycle as a LOAD is not used by that LOAD; LOAD uses the old PRESET.
- A terminal-event set and a STATUS W1C on the same edge: set wins, pending stays 1.
- Clearing IM masks irq but keeps pending; re-setting IM re-asserts irq.
- Counter arithmetic is unsigned CNT_W-bit. COUNT never decrements below 0 (no wrap).

Test Plan:
- Reset and readback: assert rst_n=0 mid-count -> all reads 0, irq=0. Then write PRESET ch0=0x12345678 -> reads back 0x12345678. A read of channel 3 with NUM_CH=2 -> 0.
- One-shot: ch0 PRESET=5, CTRL=0x09 (EN, mode0, IM) at edge t -> COUNT reads 5 after t+1 and 0 after t+6; irq[0] and irq_any rise after t+7; CTRL.EN reads 0; COUNT stays 0.
- Auto-reload plus W1C: ch1 PRESET=3, CTRL=0x0B -> irq[1] rises every 5 cycles. Write STATUS=1 -> irq[1] drops for the next cycle. A W1C landing on a terminal edge -> pending stays 1.
- Silent periodic and masking: ch0 PRESET=2, CTRL=0x05 (mode2) -> COUNT cycles 2,1,0 with reload and pending never set. Mode1 with IM=0 -> pending=1, irq=0; setting IM -> irq=1.
- Prescaler: PS=2, PRESET=2, mode0 -> COUNT decrements every 4 cycles; pending after 1+8+1=10 cycles from the write edge.
- Stop/restart: EN=0 written at COUNT=7 -> COUNT holds 7 for 20 cycles. EN=1 rewritten with PRESET changed to 9 -> COUNT=9 after LOAD. CNT_W=8 build: PRESET write 0x1FF -> reads 0xFF.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel programmable bus timer: NUM_CH down-counters with prescaler,
// one-shot / auto-reload / silent-periodic modes and W1C maskable interrupts.
//
// state   | meaning
// IDLE    | stopped, COUNT holds its value
// LOAD    | one cycle: COUNT <= PRESET, prescaler cleared
// COUNT   | counting down on prescale ticks; terminal event when COUNT==0
module multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_PRESET = 2'd1;
    localparam logic [1:0] R_COUNT  = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic [NUM_CH-1:0][31:0] ch_rdata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]       ctrl;
        logic [CNT_W-1:0] preset;
        logic [CNT_W-1:0] count;
        logic             pending;
        logic [14:0]      presc;
        logic [1:0]       state;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             wr_status;
        logic [14:0]      ps_mask;
        logic             tick;

        assign sel       = we && (addr[3:2] == 2'(c));
        assign wr_ctrl   = sel && (addr[1:0] == R_CTRL);
        assign wr_preset = sel && (addr[1:0] == R_PRESET);
        assign wr_status = sel && (addr[1:0] == R_STATUS);

        // Low PS bits set: tick when the prescaler reaches 2^PS-1.
        assign ps_mask = ~(15'h7fff << ctrl[7:4]);
        assign tick    = (presc == ps_mask);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl    <= '0;
                preset  <= '0;
                count   <= '0;
                pending <= 1'b0;
                presc   <= '0;
                state   <= S_IDLE;
            end else begin
                if (wr_preset) begin
                    preset <= wdata[CNT_W-1:0];
                end
                if (wr_status && wdata[0]) begin
                    pending <= 1'b0;
                end
                // A CTRL write overrides the running sequence: EN=1 restarts, EN=0 freezes.
                if (wr_ctrl) begin
                    ctrl  <= wdata[7:0];
                    state <= wdata[0] ? S_LOAD : S_IDLE;
                end else begin
                    case (state)
                        S_IDLE: ;
                        S_LOAD: begin
                            count <= preset;
                            presc <= '0;
                            state <= S_COUNT;
                        end
                        S_COUNT: begin
                            if (count == '0) begin
                                case (ctrl[2:1])
                                    2'd1: begin
                                        pending <= 1'b1;
                                        state   <= S_LOAD;
                                    end
                                    2'd2: state <= S_LOAD;
                                    default: begin
                                        pending <= 1'b1;
                                        ctrl[0] <= 1'b0;
                                        state   <= S_IDLE;
                                    end
                                endcase
                            end else if (tick) begin
                                count <= count - CNT_W'(1);
                                presc <= '0;
                            end else begin
                                presc <= presc + 15'd1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end

        assign irq[c] = pending & ctrl[3];

        assign ch_rdata[c] = (addr[1:0] == R_CTRL)   ? {24'b0, ctrl}   :
                             (addr[1:0] == R_PRESET) ? 32'(preset)     :
                             (addr[1:0] == R_COUNT)  ? 32'(count)      :
                                                       {31'b0, pending};
    end

    if (CNT_W < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^wdata[31:CNT_W];
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr[3:2] == 2'(c)) begin
                rdata = ch_rdata[c];
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a 2-channel 32-bit build plus a 1-channel
// 8-bit build sharing the same bus stimulus.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [1:0]  irq;
    logic        irq_any;
    logic [31:0] rdata8;
    logic [0:0]  irq8;
    logic        irq_any8;

    always #5 clk = ~clk;

    multi_timer #(.NUM_CH(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .irq_any(irq_any)
    );

    multi_timer #(.NUM_CH(1), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata8), .irq(irq8), .irq_any(irq_any8)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   seq_m2[4] = '{2, 1, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=%h exp=none", got);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] d);
        addr  = {ch, rg};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] ch, input logic [1:0] rg,
                      input logic [31:0] exp);
        push_exp(tag, exp);
        addr = {ch, rg};
        #1;
        pop_chk(rdata);
    endtask

    task automatic rd8(input string tag, input logic [1:0] ch, input logic [1:0] rg,
                       input logic [31:0] exp);
        push_exp(tag, exp);
        addr = {ch, rg};
        #1;
        pop_chk(rdata8);
    endtask

    task automatic chk_irq(input string tag, input logic [1:0] exp);
        push_exp(tag, {30'b0, exp});
        push_exp({tag, "_any"}, {31'b0, |exp});
        pop_chk({30'b0, irq});
        pop_chk({31'b0, irq_any});
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();

        // reset mid-count
        wr(2'd0, 2'd1, 32'd100);
        wr(2'd0, 2'd0, 32'h09);
        tick(3);
        rst_n = 1'b0;
        #1;
        rd("rst_ctrl", 2'd0, 2'd0, 32'h0);
        rd("rst_preset", 2'd0, 2'd1, 32'h0);
        rd("rst_count", 2'd0, 2'd2, 32'h0);
        rd("rst_status", 2'd0, 2'd3, 32'h0);
        chk_irq("rst_irq", 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        // readback and out-of-range channel
        wr(2'd0, 2'd1, 32'h1234_5678);
        rd("preset_rb", 2'd0, 2'd1, 32'h1234_5678);
        wr(2'd3, 2'd1, 32'hdead_beef);
        rd("ch3_read", 2'd3, 2'd1, 32'h0);
        wr(2'd0, 2'd2, 32'h55);
        rd("count_ro", 2'd0, 2'd2, 32'h0);

        // one-shot, P=5
        wr(2'd0, 2'd1, 32'd5);
        wr(2'd0, 2'd0, 32'h09);
        tick();
        rd("os_count_t1", 2'd0, 2'd2, 32'd5);
        tick(5);
        rd("os_count_t6", 2'd0, 2'd2, 32'd0);
        chk_irq("os_irq_t6", 2'b00);
        tick();
        chk_irq("os_irq_t7", 2'b01);
        rd("os_ctrl_en", 2'd0, 2'd0, 32'h08);
        tick(3);
        rd("os_count_hold", 2'd0, 2'd2, 32'd0);
        wr(2'd0, 2'd3, 32'h1);
        chk_irq("os_w1c", 2'b00);

        // auto-reload ch1, P=3, period 5
        wr(2'd1, 2'd1, 32'd3);
        wr(2'd1, 2'd0, 32'h0B);
        tick(4);
        chk_irq("ar_t4", 2'b00);
        tick();
        chk_irq("ar_t5", 2'b10);
        wr(2'd1, 2'd3, 32'h1);
        chk_irq("ar_w1c_t6", 2'b00);
        tick(3);
        chk_irq("ar_t9", 2'b00);
        tick();
        chk_irq("ar_t10", 2'b10);
        wr(2'd1, 2'd3, 32'h1);
        tick(3);
        chk_irq("ar_t14", 2'b00);
        wr(2'd1, 2'd3, 32'h1);
        chk_irq("ar_w1c_vs_set", 2'b10);
        rd("ar_status", 2'd1, 2'd3, 32'h1);
        wr(2'd1, 2'd0, 32'h0);
        wr(2'd1, 2'd3, 32'h1);
        chk_irq("ar_stopped", 2'b00);

        // silent periodic ch0, P=2
        wr(2'd0, 2'd1, 32'd2);
        wr(2'd0, 2'd0, 32'h05);
        for (int k = 1; k <= 10; k++) begin
            tick();
            rd($sformatf("m2_count_%0d", k), 2'd0, 2'd2, 32'(seq_m2[(k - 1) % 4]));
            rd($sformatf("m2_status_%0d", k), 2'd0, 2'd3, 32'h0);
        end
        wr(2'd0, 2'd0, 32'h0);

        // auto-reload with IM=0, then unmask
        wr(2'd0, 2'd1, 32'd1);
        wr(2'd0, 2'd0, 32'h03);
        tick(3);
        rd("mask_status", 2'd0, 2'd3, 32'h1);
        chk_irq("mask_irq", 2'b00);
        wr(2'd0, 2'd0, 32'h0B);
        chk_irq("unmask_irq", 2'b01);
        wr(2'd0, 2'd0, 32'h0);
        wr(2'd0, 2'd3, 32'h1);

        // prescaler PS=2, P=2
        wr(2'd0, 2'd1, 32'd2);
        wr(2'd0, 2'd0, 32'h29);
        tick();
        rd("ps_t1", 2'd0, 2'd2, 32'd2);
        tick(3);
        rd("ps_t4", 2'd0, 2'd2, 32'd2);
        tick();
        rd("ps_t5", 2'd0, 2'd2, 32'd1);
        tick(4);
        rd("ps_t9", 2'd0, 2'd2, 32'd0);
        chk_irq("ps_irq_t9", 2'b00);
        tick();
        chk_irq("ps_irq_t10", 2'b01);
        rd("ps_ctrl", 2'd0, 2'd0, 32'h28);
        wr(2'd0, 2'd3, 32'h1);

        // stop / restart
        wr(2'd0, 2'd1, 32'd20);
        wr(2'd0, 2'd0, 32'h01);
        tick();
        rd("stop_t1", 2'd0, 2'd2, 32'd20);
        tick(13);
        rd("stop_t14", 2'd0, 2'd2, 32'd7);
        wr(2'd0, 2'd0, 32'h00);
        rd("stop_frozen", 2'd0, 2'd2, 32'd7);
        tick(20);
        rd("stop_hold20", 2'd0, 2'd2, 32'd7);
        wr(2'd0, 2'd1, 32'd9);
        wr(2'd0, 2'd0, 32'h01);
        wr(2'd0, 2'd1, 32'd50);
        rd("restart_count", 2'd0, 2'd2, 32'd9);
        rd("restart_preset", 2'd0, 2'd1, 32'd50);
        wr(2'd0, 2'd0, 32'h0);
        wr(2'd0, 2'd3, 32'h1);

        // 8-bit build: truncation, out-of-range channel, P=0
        wr(2'd0, 2'd1, 32'h1FF);
        rd8("w8_preset", 2'd0, 2'd1, 32'hFF);
        rd("w32_preset", 2'd0, 2'd1, 32'h1FF);
        rd8("w8_ch1", 2'd1, 2'd1, 32'h0);
        wr(2'd0, 2'd1, 32'h0);
        wr(2'd0, 2'd0, 32'h09);
        tick();
        rd8("p0_count", 2'd0, 2'd2, 32'h0);
        push_exp("p0_irq8_t1", 32'h0);
        pop_chk({31'b0, irq8});
        tick();
        push_exp("p0_irq8_t2", 32'h1);
        pop_chk({31'b0, irq8});
        push_exp("p0_irq_any8_t2", 32'h1);
        pop_chk({31'b0, irq_any8});
        chk_irq("p0_irq_t2", 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
